traffic_light_ctrl: RTL and testbench

Parametrised two-road traffic light controller. A free-running prescaler generates a one-cycle tick, and a six-phase state machine sequences the two light groups. Each phase lasts a parameterised number of ticks. Adds a latched pedestrian request that extends all-red phases with a walk signal, plus a flashing-yellow maintenance mode.

---
 rtl/traffic_light_ctrl.sv | 161 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller: prescaled tick, six-phase sequence,
// latched pedestrian request served in all-red phases, flashing-yellow mode.
module traffic_light_ctrl #(
    parameter int unsigned CLK_DIV      = 100000000,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned DUR_W        = 8,
    parameter int unsigned GREEN_TICKS  = 1,
    parameter int unsigned YELLOW_TICKS = 1,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned PED_TICKS    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flash,
    input  logic       ped_req,
    output logic [2:0] light1,
    output logic [2:0] light2,
    output logic       walk,
    output logic [2:0] phase,
    output logic       tick
);

    typedef enum logic [2:0] {
        G2    = 3'd0,
        Y2    = 3'd1,
        AR1   = 3'd2,
        G1    = 3'd3,
        Y1    = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TICK_AT  = CNT_W'(CLK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_G    = DUR_W'(GREEN_TICKS);
    localparam logic [DUR_W-1:0] DUR_Y    = DUR_W'(YELLOW_TICKS);
    localparam logic [DUR_W-1:0] DUR_AR   = DUR_W'(ALLRED_TICKS);
    localparam logic [DUR_W-1:0] DUR_ARP  = DUR_W'(ALLRED_TICKS + PED_TICKS);
    localparam logic [2:0]       LAMP_G   = 3'b100;
    localparam logic [2:0]       LAMP_Y   = 3'b010;
    localparam logic [2:0]       LAMP_R   = 3'b001;
    localparam logic [2:0]       LAMP_OFF = 3'b000;

    logic [CNT_W-1:0] presc;
    logic [CNT_W-1:0] presc_nxt;
    state_t           state;
    state_t           state_nxt;
    logic [DUR_W-1:0] ph_cnt;
    logic [DUR_W-1:0] ph_cnt_nxt;
    logic [DUR_W-1:0] dur;
    logic             ped_pending;
    logic             pend_nxt;
    logic             served_nxt;
    logic             flash_on;
    logic             fon_nxt;
    logic [2:0]       l1_nxt;
    logic [2:0]       l2_nxt;

    // Normal phase rotation
    function automatic state_t seq_next(input state_t s);
        case (s)
            G2:      seq_next = Y2;
            Y2:      seq_next = AR1;
            AR1:     seq_next = G1;
            G1:      seq_next = Y1;
            Y1:      seq_next = AR2;
            default: seq_next = G2;
        endcase
    endfunction

    // Free-running prescaler next value
    always_comb begin
        presc_nxt = (presc == TICK_AT) ? '0 : presc + CNT_W'(1);
    end

    // Duration of the current phase; a served all-red phase is extended
    always_comb begin
        case (state)
            G2, G1:   dur = DUR_G;
            Y2, Y1:   dur = DUR_Y;
            AR1, AR2: dur = walk ? DUR_ARP : DUR_AR;
            default:  dur = DUR_G;
        endcase
    end

    // Next state, phase counter, pedestrian latch and flash blink
    always_comb begin
        state_nxt  = state;
        ph_cnt_nxt = ph_cnt;
        pend_nxt   = ped_pending | ped_req;
        served_nxt = walk;
        fon_nxt    = 1'b0;
        if (flash) begin
            state_nxt  = FLASH;
            ph_cnt_nxt = '0;
            served_nxt = 1'b0;
            fon_nxt    = (state == FLASH) ? (flash_on ^ tick) : 1'b1;
        end else if (state == FLASH) begin
            state_nxt  = AR2;
            ph_cnt_nxt = '0;
            served_nxt = ped_pending;
            if (ped_pending) pend_nxt = ped_req;
        end else if (tick) begin
            if (ph_cnt == dur - DUR_W'(1)) begin
                state_nxt  = seq_next(state);
                ph_cnt_nxt = '0;
                served_nxt = 1'b0;
                if ((state_nxt == AR1 || state_nxt == AR2) && ped_pending) begin
                    served_nxt = 1'b1;
                    pend_nxt   = ped_req;
                end
            end else begin
                ph_cnt_nxt = ph_cnt + DUR_W'(1);
            end
        end
    end

    // Lamp pattern for the state being entered
    always_comb begin
        l1_nxt = LAMP_R;
        l2_nxt = LAMP_R;
        case (state_nxt)
            G2:      l2_nxt = LAMP_G;
            Y2:      l2_nxt = LAMP_Y;
            G1:      l1_nxt = LAMP_G;
            Y1:      l1_nxt = LAMP_Y;
            FLASH: begin
                l1_nxt = fon_nxt ? LAMP_Y : LAMP_OFF;
                l2_nxt = fon_nxt ? LAMP_Y : LAMP_OFF;
            end
            default: ;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            tick        <= 1'b0;
            state       <= G2;
            ph_cnt      <= '0;
            ped_pending <= 1'b0;
            flash_on    <= 1'b0;
            walk        <= 1'b0;
            light1      <= LAMP_R;
            light2      <= LAMP_G;
        end else begin
            presc       <= presc_nxt;
            tick        <= (presc_nxt == TICK_AT);
            state       <= state_nxt;
            ph_cnt      <= ph_cnt_nxt;
            ped_pending <= pend_nxt;
            flash_on    <= fon_nxt;
            walk        <= served_nxt;
            light1      <= l1_nxt;
            light2      <= l2_nxt;
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with CLK_DIV=4, G=3, Y=1, AR=1, PED=2.
module tb_traffic_light_ctrl;

    logic       clk;
    logic       rst_n;
    logic       flash;
    logic       ped_req;
    logic [2:0] light1;
    logic [2:0] light2;
    logic       walk;
    logic [2:0] phase;
    logic       tick;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned t      = 0;   // edges since last reset release

    traffic_light_ctrl #(
        .CLK_DIV     (4),
        .CNT_W       (32),
        .DUR_W       (8),
        .GREEN_TICKS (3),
        .YELLOW_TICKS(1),
        .ALLRED_TICKS(1),
        .PED_TICKS   (2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .flash  (flash),
        .ped_req(ped_req),
        .light1 (light1),
        .light2 (light2),
        .walk   (walk),
        .phase  (phase),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk();
        @(posedge clk);
        #1;
        t = t + 1;
    endtask

    task automatic wait_until(input int unsigned target);
        while (t < target) wait_clk();
    endtask

    function automatic logic [2:0] exp_l1(input int p);
        case (p)
            3: exp_l1 = 3'b100;
            4: exp_l1 = 3'b010;
            default: exp_l1 = 3'b001;
        endcase
    endfunction

    function automatic logic [2:0] exp_l2(input int p);
        case (p)
            0: exp_l2 = 3'b100;
            1: exp_l2 = 3'b010;
            default: exp_l2 = 3'b001;
        endcase
    endfunction

    task automatic test_reset();
        rst_n   = 1'b0;
        flash   = 1'b0;
        ped_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (light1 !== 3'b001 || light2 !== 3'b100 || phase !== 3'd0 ||
            walk !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset: l1=%b l2=%b phase=%0d walk=%b tick=%b, want 001 100 0 0 0",
                     light1, light2, phase, walk, tick);
        end
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic test_normal_cycle();
        int p;
        for (int e = 1; e <= 40; e++) begin
            wait_clk();
            if (e < 12)      p = 0;
            else if (e < 16) p = 1;
            else if (e < 20) p = 2;
            else if (e < 32) p = 3;
            else if (e < 36) p = 4;
            else if (e < 40) p = 5;
            else             p = 0;
            checks++;
            if (phase !== 3'(p) || light1 !== exp_l1(p) || light2 !== exp_l2(p) ||
                walk !== 1'b0 || tick !== ((e % 4) == 3)) begin
                errors++;
                $display("FAIL normal_cycle t=%0d: phase=%0d l1=%b l2=%b walk=%b tick=%b, want phase=%0d l1=%b l2=%b walk=0 tick=%b",
                         e, phase, light1, light2, walk, tick, p, exp_l1(p), exp_l2(p), (e % 4) == 3);
            end
        end
    endtask

    task automatic test_ped_pulse();
        int unsigned at [5] = '{56, 67, 68, 84, 88};
        int          ep [5] = '{2, 2, 3, 5, 0};
        logic        ew [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ped_req = 1'b1;
        wait_clk();
        ped_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_until(at[i]);
            checks++;
            if (phase !== 3'(ep[i]) || walk !== ew[i]) begin
                errors++;
                $display("FAIL ped_pulse t=%0d: phase=%0d walk=%b, want phase=%0d walk=%b",
                         t, phase, walk, ep[i], ew[i]);
            end
        end
    endtask

    task automatic test_ped_held();
        int unsigned at [6] = '{104, 115, 116, 132, 143, 144};
        int          ep [6] = '{2, 2, 3, 5, 5, 0};
        logic        ew [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        ped_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wait_until(at[i]);
            if (t == 105) ped_req = 1'b0;
            checks++;
            if (phase !== 3'(ep[i]) || walk !== ew[i]) begin
                errors++;
                $display("FAIL ped_held t=%0d: phase=%0d walk=%b, want phase=%0d walk=%b",
                         t, phase, walk, ep[i], ew[i]);
            end
            if (i == 0) begin
                wait_clk();
                ped_req = 1'b0;
            end
        end
    endtask

    task automatic test_flash();
        int unsigned at [8] = '{169, 171, 172, 175, 176, 177, 187, 188};
        int          ep [8] = '{6, 6, 6, 6, 6, 5, 5, 0};
        logic [2:0]  el [8] = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b001};
        logic        ew [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [2:0]  e2;
        wait_until(168);
        flash = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_until(at[i]);
            e2 = (ep[i] == 0) ? 3'b100 : el[i];
            checks++;
            if (phase !== 3'(ep[i]) || light1 !== el[i] || light2 !== e2 || walk !== ew[i]) begin
                errors++;
                $display("FAIL flash t=%0d: phase=%0d l1=%b l2=%b walk=%b, want phase=%0d l1=%b l2=%b walk=%b",
                         t, phase, light1, light2, walk, ep[i], el[i], e2, ew[i]);
            end
            if (t == 169) begin
                wait_until(170);
                ped_req = 1'b1;
                wait_clk();
                ped_req = 1'b0;
            end
            if (t == 176) flash = 1'b0;
        end
    endtask

    task automatic test_flash_at_phase_end();
        int unsigned at [4] = '{200, 201, 203, 204};
        int          ep [4] = '{6, 5, 5, 0};
        wait_until(199);
        flash = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_until(at[i]);
            if (t == 200) flash = 1'b0;
            checks++;
            if (phase !== 3'(ep[i]) || walk !== 1'b0 ||
                light1 !== ((ep[i] == 6) ? 3'b010 : exp_l1(ep[i])) ||
                light2 !== ((ep[i] == 6) ? 3'b010 : exp_l2(ep[i]))) begin
                errors++;
                $display("FAIL flash_phase_end t=%0d: phase=%0d l1=%b l2=%b walk=%b, want phase=%0d walk=0",
                         t, phase, light1, light2, walk, ep[i]);
            end
        end
    endtask

    task automatic test_reset_mid_phase();
        wait_until(237);
        checks++;
        if (phase !== 3'd4 || light1 !== 3'b010) begin
            errors++;
            $display("FAIL pre_reset_y1: phase=%0d l1=%b, want 4 010", phase, light1);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (light1 !== 3'b001 || light2 !== 3'b100 || phase !== 3'd0 ||
            walk !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: l1=%b l2=%b phase=%0d walk=%b tick=%b, want 001 100 0 0 0",
                     light1, light2, phase, walk, tick);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        t = 0;
        wait_until(3);
        checks++;
        if (tick !== 1'b1 || phase !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_tick: tick=%b phase=%0d, want 1 0", tick, phase);
        end
        wait_until(11);
        checks++;
        if (phase !== 3'd0 || light2 !== 3'b100) begin
            errors++;
            $display("FAIL post_reset_g2_hold: phase=%0d l2=%b, want 0 100", phase, light2);
        end
        wait_until(12);
        checks++;
        if (phase !== 3'd1 || light2 !== 3'b010) begin
            errors++;
            $display("FAIL post_reset_g2_end: phase=%0d l2=%b, want 1 010", phase, light2);
        end
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_pulse();
        test_ped_held();
        test_flash();
        test_flash_at_phase_end();
        test_reset_mid_phase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
